// File: rtl/ps2_frame_rx.sv
// PS/2 receive front end on the clk_50m domain: synchronises and filters kclk/kdata,
// frames 11-bit packets, folds E0/F0 prefixes into flags and emits one event per key action.
module ps2_frame_rx #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic       clk_50m,
   input  logic       rst,
   input  logic       kclk,
   input  logic       kdata,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       is_break,
   output logic       is_extended,
   output logic       frame_err,
   output logic       busy
);

   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

   // Index 1 carries kclk, index 0 carries kdata.
   logic [1:0]     r_sync1;
   logic [1:0]     r_sync2;
   logic [1:0]     r_filt;
   logic [FCW-1:0] r_fcnt [2];
   logic           r_kclk_d;
   logic           r_fall;
   logic           r_d;

   state_t         r_state;
   logic [2:0]     r_cnt;
   logic [7:0]     r_shift;
   logic           r_par_ok;
   logic [TCW-1:0] r_tmo;
   logic           r_ext_pend;
   logic           r_brk_pend;
   logic [7:0]     r_code;
   logic           r_is_break;
   logic           r_is_ext;
   logic           r_valid;
   logic           r_err;

   state_t         w_state_nxt;
   logic [2:0]     w_cnt_nxt;
   logic [7:0]     w_shift_nxt;
   logic           w_par_ok_nxt;
   logic [TCW-1:0] w_tmo_nxt;
   logic           w_ext_nxt;
   logic           w_brk_nxt;
   logic [7:0]     w_code_nxt;
   logic           w_is_break_nxt;
   logic           w_is_ext_nxt;
   logic           w_valid_nxt;
   logic           w_err_nxt;

   // Synchroniser, glitch filter and registered kclk falling-edge detect.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         r_sync1  <= 2'b11;
         r_sync2  <= 2'b11;
         r_filt   <= 2'b11;
         for (int i = 0; i < 2; i++) begin
            r_fcnt[i] <= '0;
         end
         r_kclk_d <= 1'b1;
         r_fall   <= 1'b0;
         r_d      <= 1'b1;
      end else begin
         r_sync1 <= {kclk, kdata};
         r_sync2 <= r_sync1;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_filt[i]) begin
               r_fcnt[i] <= '0;
            end else if (r_fcnt[i] == FCW'(FILTER_LEN - 1)) begin
               r_filt[i] <= r_sync2[i];
               r_fcnt[i] <= '0;
            end else begin
               r_fcnt[i] <= r_fcnt[i] + FCW'(1);
            end
         end
         r_kclk_d <= r_filt[1];
         r_fall   <= r_kclk_d & ~r_filt[1];
         r_d      <= r_filt[0];
      end
   end

   // Frame state and registered event outputs.
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 3'd0;
         r_shift    <= 8'h00;
         r_par_ok   <= 1'b0;
         r_tmo      <= '0;
         r_ext_pend <= 1'b0;
         r_brk_pend <= 1'b0;
         r_code     <= 8'h00;
         r_is_break <= 1'b0;
         r_is_ext   <= 1'b0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_par_ok   <= w_par_ok_nxt;
         r_tmo      <= w_tmo_nxt;
         r_ext_pend <= w_ext_nxt;
         r_brk_pend <= w_brk_nxt;
         r_code     <= w_code_nxt;
         r_is_break <= w_is_break_nxt;
         r_is_ext   <= w_is_ext_nxt;
         r_valid    <= w_valid_nxt;
         r_err      <= w_err_nxt;
      end
   end

   // Next-state, framing checks, prefix folding and timeout abort.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_shift_nxt    = r_shift;
      w_par_ok_nxt   = r_par_ok;
      w_ext_nxt      = r_ext_pend;
      w_brk_nxt      = r_brk_pend;
      w_code_nxt     = r_code;
      w_is_break_nxt = r_is_break;
      w_is_ext_nxt   = r_is_ext;
      w_valid_nxt    = 1'b0;
      w_err_nxt      = 1'b0;
      if (r_state == S_IDLE || r_fall) begin
         w_tmo_nxt = '0;
      end else begin
         w_tmo_nxt = r_tmo + TCW'(1);
      end

      if (r_fall) begin
         case (r_state)
            S_IDLE: begin
               if (!r_d) begin
                  w_state_nxt = S_DATA;
                  w_cnt_nxt   = 3'd0;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_DATA: begin
               w_shift_nxt[r_cnt] = r_d;
               if (r_cnt == 3'd7) begin
                  w_state_nxt = S_PARITY;
               end else begin
                  w_cnt_nxt = r_cnt + 3'd1;
               end
            end
            S_PARITY: begin
               w_par_ok_nxt = odd_parity_ok(r_shift, r_d);
               w_state_nxt  = S_STOP;
            end
            S_STOP: begin
               w_state_nxt = S_IDLE;
               if (r_d && r_par_ok) begin
                  case (r_shift)
                     8'hE0:   w_ext_nxt = 1'b1;
                     8'hF0:   w_brk_nxt = 1'b1;
                     default: begin
                        w_code_nxt     = r_shift;
                        w_is_break_nxt = r_brk_pend;
                        w_is_ext_nxt   = r_ext_pend;
                        w_valid_nxt    = 1'b1;
                        w_ext_nxt      = 1'b0;
                        w_brk_nxt      = 1'b0;
                     end
                  endcase
               end else begin
                  w_err_nxt = 1'b1;
                  w_ext_nxt = 1'b0;
                  w_brk_nxt = 1'b0;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end else if (r_state != S_IDLE && r_tmo == TCW'(TIMEOUT_CYC - 1)) begin
         w_state_nxt = S_IDLE;
         w_err_nxt   = 1'b1;
         w_ext_nxt   = 1'b0;
         w_brk_nxt   = 1'b0;
      end else begin
         w_state_nxt = r_state;
      end
   end

   assign code        = r_code;
   assign code_valid  = r_valid;
   assign is_break    = r_is_break;
   assign is_extended = r_is_ext;
   assign frame_err   = r_err;
   assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Scoreboard bench for ps2_frame_rx: directed PS/2 frames push expected events,
// a negedge monitor pops and compares them whenever code_valid or frame_err fires.
module tb_ps2_frame_rx;

   localparam int FL = 8;
   localparam int TC = 400;
   localparam int HP = 30;

   logic       clk_50m = 1'b0;
   logic       rst     = 1'b1;
   logic       kclk    = 1'b1;
   logic       kdata   = 1'b1;
   logic [7:0] code;
   logic       code_valid;
   logic       is_break;
   logic       is_extended;
   logic       frame_err;
   logic       busy;

   ps2_frame_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TC)) dut (
      .clk_50m     (clk_50m),
      .rst         (rst),
      .kclk        (kclk),
      .kdata       (kdata),
      .code        (code),
      .code_valid  (code_valid),
      .is_break    (is_break),
      .is_extended (is_extended),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   always #10 clk_50m = ~clk_50m;

   int cyc = 0;
   always @(posedge clk_50m) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] code;
      logic       brk;
      logic       ext;
   } ev_t;

   ev_t ev_q[$];
   bit  err_q[$];
   ev_t mon_e;
   bit  mon_t;
   int  n_cmp = 0;
   int  n_bad = 0;
   int  stop_cyc = 0;
   int  last_fall_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   always @(negedge clk_50m) begin
      if (!rst) begin
         if (code_valid || frame_err)
            check("valid_err_exclusive", {31'd0, code_valid & frame_err}, 32'd0);
         if (code_valid) begin
            if (ev_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_code_valid: got code %0h expected no event", code);
            end else begin
               mon_e = ev_q.pop_front();
               check("code", {24'd0, code}, {24'd0, mon_e.code});
               check("is_break", {31'd0, is_break}, {31'd0, mon_e.brk});
               check("is_extended", {31'd0, is_extended}, {31'd0, mon_e.ext});
               check("latency", cyc - stop_cyc, FL + 4);
            end
         end
         if (frame_err) begin
            if (err_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_frame_err: got frame_err=1 expected 0");
            end else begin
               mon_t = err_q.pop_front();
               if (mon_t) check("timeout_delay", cyc - last_fall_cyc, FL + 4 + TC);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_50m);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         kdata = fr[i];
         tick(HP);
         kclk = 1'b0;
         last_fall_cyc = cyc;
         if (i == 10) stop_cyc = cyc;
         tick(HP);
         kclk = 1'b1;
      end
      kdata = 1'b1;
      tick(2 * HP);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_code"}, {24'd0, code}, 32'd0);
      check({tag, "_code_valid"}, {31'd0, code_valid}, 32'd0);
      check({tag, "_is_break"}, {31'd0, is_break}, 32'd0);
      check({tag, "_is_extended"}, {31'd0, is_extended}, 32'd0);
      check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      tick(5);
      check_all_zero("reset");
      rst = 1'b0;
      tick(20);

      // 1: plain make code
      ev_q.push_back('{8'h1D, 1'b0, 1'b0});
      send_frame(8'h1D, 1'b0, 11);
      check("busy_after_stop", {31'd0, busy}, 32'd0);

      // 2: break code
      send_frame(8'hF0, 1'b0, 11);
      ev_q.push_back('{8'h1D, 1'b1, 1'b0});
      send_frame(8'h1D, 1'b0, 11);

      // 3: extended break, then plain make clears flags
      send_frame(8'hE0, 1'b0, 11);
      send_frame(8'hF0, 1'b0, 11);
      ev_q.push_back('{8'h75, 1'b1, 1'b1});
      send_frame(8'h75, 1'b0, 11);
      ev_q.push_back('{8'h72, 1'b0, 1'b0});
      send_frame(8'h72, 1'b0, 11);

      // 4: parity error, code holds; then good frame
      err_q.push_back(1'b0);
      send_frame(8'h29, 1'b1, 11);
      check("code_hold_after_err", {24'd0, code}, 32'h72);
      ev_q.push_back('{8'h29, 1'b0, 1'b0});
      send_frame(8'h29, 1'b0, 11);

      // 5: truncated frame times out
      err_q.push_back(1'b1);
      send_frame(8'h70, 1'b0, 6);
      check("busy_mid_frame", {31'd0, busy}, 32'd1);
      tick(TC + FL + 20);
      check("busy_after_timeout", {31'd0, busy}, 32'd0);
      ev_q.push_back('{8'h70, 1'b0, 1'b0});
      send_frame(8'h70, 1'b0, 11);

      // 6: short kclk glitch while idle
      kclk = 1'b0;
      tick(FL - 3);
      kclk = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("busy_glitch", {31'd0, busy}, 32'd0);
      end

      // 6: reset during bit 4 of a frame
      send_frame(8'h6B, 1'b0, 5);
      check("busy_before_rst", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      tick(3);
      check_all_zero("midframe_rst");
      rst = 1'b0;
      tick(20);
      ev_q.push_back('{8'h6B, 1'b0, 1'b0});
      send_frame(8'h6B, 1'b0, 11);

      tick(200);
      check("events_outstanding", ev_q.size(), 32'd0);
      check("errors_outstanding", err_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
